// File: rtl/pocket_video_out.sv
// Pocket video output stage: registers timing-generator sync/blank/RGB onto the Pocket bus and measures active geometry.
// Optional end-of-line marker word on video_rgb is enabled by defining POCKET_EOL_EN.
module pocket_video_out #(
  parameter int unsigned EXP_W    = 256,
  parameter int unsigned EXP_H    = 240,
  parameter logic [23:0] EOL_WORD = 24'h000000
) (
  input  logic        vclk,
  input  logic        reset,
  input  logic [23:0] rgbin,
  input  logic        hb,
  input  logic        vb,
  input  logic        hs,
  input  logic        vs,
  output logic [23:0] video_rgb,
  output logic        video_de,
  output logic        video_hs,
  output logic        video_vs,
  output logic [9:0]  active_w,
  output logic [8:0]  active_h,
  output logic [15:0] frame_cnt,
  output logic        geom_ok
);

  localparam int unsigned W_BITS = 10;
  localparam int unsigned H_BITS = 9;
  localparam int unsigned F_BITS = 16;

`ifdef POCKET_EOL_EN
  localparam bit EOL_EN = 1'b1;
`else
  localparam bit EOL_EN = 1'b0;
`endif

  logic              hs_q;
  logic              vs_q;
  logic              first_frame;
  logic [W_BITS-1:0] pix_cnt;
  logic [H_BITS-1:0] line_cnt;

  logic              de_c;
  logic              de_fall_c;
  logic              hs_fall_c;
  logic              vs_fall_c;
  logic [H_BITS-1:0] lines_c;
  logic [W_BITS-1:0] width_c;
  logic [23:0]       blank_rgb_c;

  // Edge detection; lines_c/width_c fold in a de fall landing on the vs edge.
  always_comb begin
    de_c        = !hb && !vb;
    de_fall_c   = video_de && !de_c;
    hs_fall_c   = hs_q && !hs;
    vs_fall_c   = vs_q && !vs;
    lines_c     = line_cnt;
    if (de_fall_c && (line_cnt != '1)) lines_c = line_cnt + H_BITS'(1);
    width_c     = de_fall_c ? pix_cnt : active_w;
    blank_rgb_c = (EOL_EN && de_fall_c) ? EOL_WORD : 24'h000000;
  end

  always_ff @(posedge vclk) begin
    if (reset) begin
      video_rgb   <= '0;
      video_de    <= 1'b0;
      video_hs    <= 1'b0;
      video_vs    <= 1'b0;
      active_w    <= '0;
      active_h    <= '0;
      frame_cnt   <= '0;
      geom_ok     <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      first_frame <= 1'b1;
      pix_cnt     <= '0;
      line_cnt    <= '0;
    end else begin
      hs_q      <= hs;
      vs_q      <= vs;
      video_de  <= de_c;
      video_hs  <= hs_fall_c;
      video_vs  <= vs_fall_c;
      video_rgb <= de_c ? rgbin : blank_rgb_c;

      // Pixel counter saturates; latched into active_w when the line ends.
      if (de_fall_c) begin
        active_w <= pix_cnt;
        pix_cnt  <= '0;
      end else if (de_c && (pix_cnt != '1)) begin
        pix_cnt <= pix_cnt + W_BITS'(1);
      end

      // The first vs after reset only arms measurement; the partial frame is discarded.
      if (vs_fall_c) begin
        active_h  <= lines_c;
        line_cnt  <= '0;
        frame_cnt <= frame_cnt + F_BITS'(1);
        if (first_frame) begin
          first_frame <= 1'b0;
        end else begin
          geom_ok <= (width_c == W_BITS'(EXP_W)) && (lines_c == H_BITS'(EXP_H));
        end
      end else begin
        line_cnt <= lines_c;
      end
    end
  end

endmodule

// File: doc/pocket_video_out.md
Name: pocket_video_out

Overview:
- Output stage directly downstream of the core's H/V timing generator.
- Converts its active-low sync levels, blank flags and blanked RGB into the registered Pocket video bus:
  - single-cycle sync pulses
  - data enable
  - RGB forced to zero outside active video
- Also measures active width/height per frame and flags a geometry match, for bring-up and status.

Parameters:
- EXP_W, 256, expected active pixels per line.
- EXP_H, 240, expected active lines per frame.
- EOL_WORD, 24'h000000, value driven on video_rgb on the end-of-line cycle (used only with the optional feature).

Ports:
- vclk  in  1  pixel clock, the same clock that drives the timing generator
- reset  in  1  synchronous, active-high
- rgbin  in  24  pixel data from timing generator
- hb  in  1  horizontal blank, active high
- vb  in  1  vertical blank, active high
- hs  in  1  horizontal sync, active low level
- vs  in  1  vertical sync, active low level
- video_rgb  out  24  registered pixel data
- video_de  out  1  data enable
- video_hs  out  1  one-cycle HS pulse, active high
- video_vs  out  1  one-cycle VS pulse, active high
- active_w  out  10  active pixels of last completed line
- active_h  out  9  active lines of last completed frame
- frame_cnt  out  16  completed-frame counter
- geom_ok  out  1  last full frame matched EXP_W x EXP_H

Behaviour:
- Clock and reset: one clock, vclk. Reset is synchronous, active-high.
- Reset values:
  - All outputs are 0.
  - Internal hs_q/vs_q (previous-sample registers) are 1, so the first low sample after reset is treated as a falling edge. An input already low at reset release therefore produces one pulse.
  - Internal pixel/line counters are 0.
  - Internal first_frame flag is 1.
- Latency: every output is registered and reflects the inputs sampled on the same vclk edge, so there is 1 cycle of latency for all video signals. Sync/DE/RGB alignment is preserved.
- video_de:
  - video_de = !hb && !vb.
  - video_rgb = rgbin when de, else 0.
- video_hs = hs_q && !hs, i.e. a falling edge on hs. video_vs is the same function on vs.
  - Exactly one cycle high per falling edge.
  - A held-low input does not re-pulse.
- Pixel counter (10 bit, saturates at 1023):
  - Increments on each de cycle.
  - On the de falling edge (de_q && !de), latches its value into active_w, then clears.
  - If de rises on the same cycle the counter clears, it restarts at 1.
- Line counter (9 bit, saturates at 511): increments once per de falling edge.
- On a video_vs pulse:
  - Latch the line count into active_h, including a line whose de falling edge is on the same cycle.
  - Clear the line counter.
  - frame_cnt += 1, wrapping from 65535 to 0.
  - If first_frame=1: clear first_frame, leave geom_ok at 0.
  - Else: geom_ok = (active_w==EXP_W && latched height==EXP_H).
- Simultaneous hs and vs falling edges: both pulses are asserted on the same cycle.
- Reset mid-frame:
  - Counters clear.
  - The partial frame is discarded via first_frame.
  - geom_ok stays 0 until one complete vs-to-vs frame is observed.
- Blanking edges with no de activity in a frame: active_h=0, so geom_ok=0.

Optional Feature:
- Macro: POCKET_EOL_EN.
- Defined:
  - On the first cycle after each de falling edge, video_rgb = EOL_WORD while video_de=0.
  - All other blank cycles are 0.
  - Timing of video_de, video_hs and video_vs is unchanged.
- Undefined: video_rgb is always 0 whenever video_de=0, and the EOL_WORD parameter is ignored.

Test Plan:
- Reset held 3 cycles with hs=vs=1 -> all outputs 0. Release -> no pulses. First hs falling edge -> video_hs=1 for exactly 1 cycle, 1 cycle after the input edge.
- hb=0, vb=0, rgbin=24'hA5C3F0 -> next cycle video_de=1, video_rgb=24'hA5C3F0. hb=1 with rgbin nonzero -> video_rgb=0, video_de=0.
- Drive 256 de cycles per line, 240 lines, then a vs falling edge; repeat 2 frames:
  - after frame 1: active_w=256, active_h=240, frame_cnt=1, geom_ok=0
  - after frame 2: geom_ok=1, frame_cnt=2
- Third frame with 255-pixel lines -> active_w=255, geom_ok=0 after its vs. Assert reset mid-frame, then 2 correct frames -> geom_ok=1 only after the second post-reset vs.
- hs and vs falling on the same cycle -> video_hs=video_vs=1 on the same single cycle. Last de falling edge coincident with the vs edge -> active_h counts that line (240).
- With POCKET_EOL_EN, EOL_WORD=24'h00_1234 -> cycle after each de falling edge shows video_rgb=24'h001234, video_de=0, then 0. Without the macro -> 0.
